// File: rtl/ps2_rx_pkg.sv
// Shared constants, byte type and parity helper for the PS/2 receiver.
package ps2_rx_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned START_IDX  = 0;
  localparam int unsigned PARITY_IDX = 9;
  localparam int unsigned STOP_IDX   = 10;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 4;

  typedef logic [BYTE_W-1:0] byte_t;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input byte_t d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Byte FIFO for received scan codes; pointers carry one extra wrap bit.
module ps2_rx_fifo
  import ps2_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk,
  input  logic  clrn,
  input  logic  push,
  input  byte_t din,
  input  logic  pop,
  output byte_t dout,
  output logic  empty,
  output logic  full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  byte_t       mem [DEPTH];
  logic        do_pop_c;
  logic        do_push_c;

  // Status flags, head data and qualified push/pop.
  always_comb begin
    empty     = (wptr == rptr);
    full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    do_pop_c  = pop & ~empty;
    do_push_c = push & (~full | do_pop_c);
    dout      = empty ? '0 : mem[rptr[AW-1:0]];
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wptr[AW-1:0]] <= din;
  end

  // Pointer update, wrapping naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push_c) wptr <= wptr + (AW+1)'(1);
      if (do_pop_c)  rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ps2_rx_core.sv
// PS/2 device-to-host receiver: pin synchroniser, 11-bit deserialiser,
// frame check and scan-code FIFO. Optional mid-frame timeout is enabled
// with the PS2_RX_TIMEOUT_EN macro.
module ps2_rx_core
  import ps2_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              nextdata_n,
  output logic [BYTE_W-1:0] data,
  output logic              ready,
  output logic              overflow,
  output logic              frame_err
);

  logic [2:0]            clk_sync;
  logic [1:0]            data_sync;
  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_c;
  logic                  fall_c;
  logic                  bit_c;
  logic                  done_c;
  logic                  valid_c;
  logic                  push_req_c;
  logic                  pop_c;
  logic                  drop_c;
  logic                  timeout_c;
  logic                  empty_c;
  logic                  full_c;

  // Bring the asynchronous pins into the clk domain; idle bus level is 1.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Edge detect and frame validation; the last bit is checked as it arrives.
  always_comb begin
    fall_c             = clk_sync[2] & ~clk_sync[1];
    bit_c              = data_sync[1];
    frame_c            = shreg;
    frame_c[STOP_IDX]  = bit_c;
    done_c             = fall_c && (cnt == CNT_W'(STOP_IDX));
    valid_c            = ~frame_c[START_IDX] & frame_c[STOP_IDX] &
                         odd_parity_ok(frame_c[START_IDX+1 +: BYTE_W], frame_c[PARITY_IDX]);
    push_req_c         = done_c & valid_c;
    pop_c              = ~nextdata_n & ~empty_c;
    drop_c             = push_req_c & full_c & ~pop_c;
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt;

  assign timeout_c = (cnt != '0) && !fall_c && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Inactivity counter, running only while a frame is in progress.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      to_cnt <= '0;
    end else if (fall_c || (cnt == '0) || timeout_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  wire unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign timeout_c = 1'b0;
`endif

  // Bit capture at the current bit index; a timeout abandons the frame.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (timeout_c) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (fall_c) begin
      shreg[cnt] <= bit_c;
      cnt        <= done_c ? '0 : cnt + CNT_W'(1);
    end
  end

  // Sticky overflow and one-cycle error pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= (done_c & ~valid_c) | timeout_c;
      if (drop_c)     overflow <= 1'b1;
      else if (pop_c) overflow <= 1'b0;
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push_req_c),
    .din   (frame_c[START_IDX+1 +: BYTE_W]),
    .pop   (pop_c),
    .dout  (data),
    .empty (empty_c),
    .full  (full_c)
  );

  assign ready = ~empty_c;

endmodule

// File: tb/tb_ps2_rx_core.sv
// Scoreboard bench for ps2_rx_core: directed PS/2 frames, expected bytes
// queued at send time and compared by a monitor on every pop.
module tb_ps2_rx_core;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TO_CYC = 100;
`else
  localparam int unsigned TO_CYC = 50000;
`endif

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  int         n_checks = 0;
  int         n_fail = 0;
  int         err_cnt = 0;
  int         err_base;
  logic [7:0] exp_q [$];

  ps2_rx_core #(
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (clrn && ready && !nextdata_n) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected nothing", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h", data, e);
        end
      end
    end
    if (clrn && frame_err) err_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: plain; 1: check latency of the final edge; 2: pop in the completion cycle.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int mode);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      cyc(20);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lat_not_yet", 32'(ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_ready", 32'(ready), 32'd1);
        check("lat_data", 32'(data), 32'h1c);
        cyc(16);
      end else if (i == 10 && mode == 2) begin
        repeat (2) @(posedge clk);
        #1 nextdata_n = 1'b0;
        @(posedge clk);
        #1 nextdata_n = 1'b1;
        cyc(17);
      end else begin
        cyc(20);
      end
      ps2_clk = 1'b1;
    end
    cyc(40);
  endtask

  task automatic pop_one();
    @(negedge clk);
    check("pop_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 nextdata_n = 1'b0;
    @(posedge clk);
    #1 nextdata_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    cyc(3);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    clrn = 1'b1;
    cyc(5);

    // Single valid frame with latency check, then pop.
    exp_q.push_back(8'h1c);
    send_frame(8'h1c, 1'b0, 11, 1);
    pop_one();
    check("t1_ready_after_pop", 32'(ready), 32'd0);

    // Bad parity: one error pulse, nothing queued.
    err_base = err_cnt;
    send_frame(8'h1c, 1'b1, 11, 0);
    check("t2_err_pulses", 32'(err_cnt - err_base), 32'd1);
    check("t2_ready", 32'(ready), 32'd0);

    // Nine frames without pops: the ninth is dropped.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 11, 0);
      if (i == 8) check("t3_no_ovf_at_8", 32'(overflow), 32'd0);
    end
    check("t3_overflow", 32'(overflow), 32'd1);
    pop_one();
    check("t3_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) pop_one();
    check("t3_empty", 32'(ready), 32'd0);
    check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // Full FIFO with a pop in the completion cycle of the ninth frame.
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b0, 11, 0);
    end
    exp_q.push_back(8'h09);
    send_frame(8'h09, 1'b0, 11, 2);
    check("t4_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop_one();
    check("t4_empty", 32'(ready), 32'd0);
    check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    err_base = err_cnt;
    send_frame(8'h33, 1'b0, 5, 0);
    clrn = 1'b0;
    cyc(2);
    check("t5_ready_in_rst", 32'(ready), 32'd0);
    clrn = 1'b1;
    cyc(5);
    exp_q.push_back(8'hf0);
    send_frame(8'hf0, 1'b0, 11, 0);
    check("t5_no_err", 32'(err_cnt - err_base), 32'd0);
    pop_one();
    check("t5_empty", 32'(ready), 32'd0);

`ifdef PS2_RX_TIMEOUT_EN
    // Abandoned partial frame times out, next frame is clean.
    err_base = err_cnt;
    send_frame(8'h77, 1'b0, 4, 0);
    cyc(110);
    check("t6_timeout_err", 32'(err_cnt - err_base), 32'd1);
    check("t6_ready", 32'(ready), 32'd0);
    exp_q.push_back(8'h5a);
    send_frame(8'h5a, 1'b0, 11, 0);
    check("t6_err_total", 32'(err_cnt - err_base), 32'd1);
    pop_one();
`endif

    cyc(5);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
